// File: rtl/cfu_pkg.sv
// Shared widths, FSM state encoding and request payload for the CFU initiator.
package cfu_pkg;

  localparam int unsigned FUNC_ID_W = 10;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_e;

  typedef struct packed {
    logic [FUNC_ID_W-1:0] function_id;
    logic [DATA_W-1:0]    in0;
    logic [DATA_W-1:0]    in1;
  } cfu_req_t;

endpackage

// File: rtl/cfu_req_fifo.sv
// Request queue: power-of-two depth, extra pointer bit separates full from empty.
module cfu_req_fifo
  import cfu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  cfu_req_t wdata,
  input  logic     pop,
  output cfu_req_t rdata,
  output logic     ready,
  output logic     empty,
  output logic     empty_next_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  cfu_req_t      mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_ptr_d, rd_ptr_d;
  logic          do_push, do_pop;

  // A push while full is legal only when the head leaves in the same cycle.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (ready || do_pop);
  assign wr_ptr_d = wr_ptr + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr + (AW+1)'(do_pop);

  assign empty_next_c = (wr_ptr_d == rd_ptr_d);
  assign rdata        = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b1;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      empty  <= empty_next_c;
      ready  <= !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cfu_initiator.sv
// Queues CFU requests and drives them one at a time over a valid/ready CFU
// command/response bus, with a response timeout and stray-response counting.
module cfu_initiator
  import cfu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FUNC_ID_W-1:0] req_function_id,
  input  logic [DATA_W-1:0]    req_in0,
  input  logic [DATA_W-1:0]    req_in1,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic [FUNC_ID_W-1:0] res_function_id,
  output logic                 res_error,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [FUNC_ID_W-1:0] cmd_payload_function_id,
  output logic [DATA_W-1:0]    cmd_payload_inputs_0,
  output logic [DATA_W-1:0]    cmd_payload_inputs_1,
  input  logic                 rsp_valid,
  output logic                 rsp_ready,
  input  logic [DATA_W-1:0]    rsp_payload_outputs_0,
  output logic [7:0]           stray_count,
  output logic                 busy
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

  state_e              state, state_d;
  logic [TIMER_W-1:0]  timer;
  cfu_req_t            fifo_wdata, fifo_rdata;
  logic                fifo_push, fifo_pop;
  logic                fifo_ready, fifo_empty, fifo_empty_next_c;
  logic                load, timer_clr, timer_inc;
  logic                cap_rsp, cap_timeout, stray_inc;

  assign req_ready  = fifo_ready;
  assign fifo_push  = req_valid && fifo_ready;
  assign fifo_wdata = '{function_id: req_function_id, in0: req_in0, in1: req_in1};

  cfu_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (fifo_push),
    .wdata        (fifo_wdata),
    .pop          (fifo_pop),
    .rdata        (fifo_rdata),
    .ready        (fifo_ready),
    .empty        (fifo_empty),
    .empty_next_c (fifo_empty_next_c)
  );

  // Next-state and control strobes.
  always_comb begin
    state_d     = state;
    fifo_pop    = 1'b0;
    load        = 1'b0;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;
    cap_rsp     = 1'b0;
    cap_timeout = 1'b0;
    stray_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        stray_inc = rsp_valid;
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        stray_inc = rsp_valid;
        if (cmd_ready) begin
          fifo_pop  = 1'b1;
          timer_clr = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response arriving on the timeout cycle still counts as success.
        if (rsp_valid) begin
          cap_rsp = 1'b1;
          state_d = ST_DELIVER;
        end else if (timer == TIMER_W'(TIMEOUT)) begin
          cap_timeout = 1'b1;
          state_d     = ST_DELIVER;
        end else begin
          timer_inc = 1'b1;
        end
      end
      ST_DELIVER: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= ST_IDLE;
      timer                   <= '0;
      stray_count             <= '0;
      cmd_valid               <= 1'b0;
      res_valid               <= 1'b0;
      rsp_ready               <= 1'b1;
      busy                    <= 1'b0;
      cmd_payload_function_id <= '0;
      cmd_payload_inputs_0    <= '0;
      cmd_payload_inputs_1    <= '0;
      res_data                <= '0;
      res_function_id         <= '0;
      res_error               <= 1'b0;
    end else begin
      state     <= state_d;
      cmd_valid <= (state_d == ST_ISSUE);
      res_valid <= (state_d == ST_DELIVER);
      rsp_ready <= (state_d != ST_DELIVER);
      busy      <= (state_d != ST_IDLE) || !fifo_empty_next_c;

      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + TIMER_W'(1);

      if (stray_inc && (stray_count != 8'hFF)) stray_count <= stray_count + 8'd1;

      if (load) begin
        cmd_payload_function_id <= fifo_rdata.function_id;
        cmd_payload_inputs_0    <= fifo_rdata.in0;
        cmd_payload_inputs_1    <= fifo_rdata.in1;
      end

      if (cap_rsp || cap_timeout) begin
        res_data        <= cap_rsp ? rsp_payload_outputs_0 : '0;
        res_error       <= cap_timeout;
        res_function_id <= cmd_payload_function_id;
      end
    end
  end

endmodule

// File: tb/tb_cfu_initiator.sv
// Directed bench for cfu_initiator with a single-cycle RAM-backed CFU model.
module tb_cfu_initiator;
  import cfu_pkg::*;

  logic                 clk;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic [FUNC_ID_W-1:0] req_function_id;
  logic [DATA_W-1:0]    req_in0;
  logic [DATA_W-1:0]    req_in1;
  logic                 res_valid;
  logic                 res_ready;
  logic [DATA_W-1:0]    res_data;
  logic [FUNC_ID_W-1:0] res_function_id;
  logic                 res_error;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [FUNC_ID_W-1:0] cmd_payload_function_id;
  logic [DATA_W-1:0]    cmd_payload_inputs_0;
  logic [DATA_W-1:0]    cmd_payload_inputs_1;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_payload_outputs_0;
  logic [7:0]           stray_count;
  logic                 busy;

  int n_checks;
  int n_err;
  logic        cfu_auto;
  logic [31:0] ram [16];
  logic [9:0]  t_fid [5];
  logic [31:0] t_a   [5];
  logic [31:0] t_b   [5];
  logic [31:0] t_exp [5];

  cfu_initiator #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (255)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_function_id         (req_function_id),
    .req_in0                 (req_in0),
    .req_in1                 (req_in1),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_data                (res_data),
    .res_function_id         (res_function_id),
    .res_error               (res_error),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .stray_count             (stray_count),
    .busy                    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; the CFU model answers the cycle after a command handshake.
  task automatic tick();
    logic        hs;
    logic [31:0] d;
    hs = cfu_auto && cmd_valid && cmd_ready;
    d  = '0;
    if (hs) begin
      if (cmd_payload_function_id[0]) begin
        ram[cmd_payload_inputs_0[3:0]] = cmd_payload_inputs_1;
        d = cmd_payload_inputs_1;
      end else begin
        d = ram[cmd_payload_inputs_0[3:0]];
      end
    end
    @(posedge clk);
    #1;
    if (cfu_auto) begin
      rsp_valid             = hs;
      rsp_payload_outputs_0 = d;
    end
  endtask

  task automatic push_one(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    req_valid       = 1'b1;
    req_function_id = f;
    req_in0         = a;
    req_in1         = b;
    tick();
    req_valid       = 1'b0;
  endtask

  task automatic wait_res(input int budget, input string tag);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(res_valid), 32'd1);
  endtask

  task automatic wait_issue(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      seen = cmd_valid && cmd_ready;
      tick();
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int   got;
    logic acc;
    logic stale;
    n_checks = 0;
    n_err    = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_function_id = '0; req_in0 = '0; req_in1 = '0;
    res_ready = 1'b0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_payload_outputs_0 = '0;
    cfu_auto = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    t_fid = '{10'h011, 10'h012, 10'h014, 10'h017, 10'h018};
    t_a   = '{32'd3, 32'd3, 32'd5, 32'd7, 32'd7};
    t_b   = '{32'h1111, 32'h0, 32'h0, 32'hA5A5, 32'h0};
    t_exp = '{32'h1111, 32'h1111, 32'hDEADBEEF, 32'hA5A5, 32'hA5A5};

    // Reset state
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_ready", 32'(rsp_ready), 32'd1);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_error", 32'(res_error), 32'd0);
    chk("rst_stray",     32'(stray_count), 32'd0);
    chk("rst_res_data",  res_data, 32'd0);
    chk("rst_cmd_fid",   32'(cmd_payload_function_id), 32'd0);
    chk("rst_cmd_in0",   cmd_payload_inputs_0, 32'd0);
    reset = 1'b0;
    tick();

    // Stray responses while idle, saturating at 255
    rsp_valid = 1'b1;
    tick(); tick();
    chk("stray_2", 32'(stray_count), 32'd2);
    repeat (260) tick();
    chk("stray_sat", 32'(stray_count), 32'd255);
    rsp_valid = 1'b0;
    tick();

    // Write then read through the CFU RAM, with latency and hold checks
    cfu_auto  = 1'b1;
    cmd_ready = 1'b1;
    push_one(10'h001, 32'd5, 32'hDEADBEEF);
    chk("lat_cyc1_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("busy_after_push",    32'(busy), 32'd1);
    tick();
    chk("lat_cyc2_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("wr_cmd_fid",         32'(cmd_payload_function_id), 32'h001);
    chk("wr_cmd_in1",         cmd_payload_inputs_1, 32'hDEADBEEF);
    tick();
    chk("wait_res_valid",     32'(res_valid), 32'd0);
    tick();
    chk("res_lat_valid",      32'(res_valid), 32'd1);
    chk("wr_res_fid",         32'(res_function_id), 32'h001);
    chk("wr_res_error",       32'(res_error), 32'd0);
    chk("deliver_rsp_ready",  32'(rsp_ready), 32'd0);
    tick(); tick();
    chk("res_hold_valid",     32'(res_valid), 32'd1);
    chk("res_hold_fid",       32'(res_function_id), 32'h001);
    chk("res_hold_data",      res_data, 32'hDEADBEEF);
    res_ready = 1'b1;
    tick();
    chk("res_drop",           32'(res_valid), 32'd0);
    push_one(10'h000, 32'd5, 32'd0);
    wait_res(20, "rd_res_arrive");
    chk("rd_res_data",  res_data, 32'hDEADBEEF);
    chk("rd_res_error", 32'(res_error), 32'd0);
    chk("rd_res_fid",   32'(res_function_id), 32'h000);
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Stalled command with a full queue, then in-order drain
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_req_ready", 32'(req_ready), 32'd1);
      push_one(t_fid[i], t_a[i], t_b[i]);
    end
    chk("full_req_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 10; k++) begin
      chk("stall_cmd_valid", 32'(cmd_valid), 32'd1);
      chk("stall_fid",       32'(cmd_payload_function_id), 32'(t_fid[0]));
      chk("stall_in0",       cmd_payload_inputs_0, t_a[0]);
      chk("stall_in1",       cmd_payload_inputs_1, t_b[0]);
      chk("stall_no_pop",    32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 1'b1; req_function_id = t_fid[4]; req_in0 = t_a[4]; req_in1 = t_b[4];
    cmd_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 80 && got < 5; n++) begin
      acc = req_valid && req_ready;
      tick();
      if (acc) req_valid = 1'b0;
      if (res_valid) begin
        chk("order_fid",   32'(res_function_id), 32'(t_fid[got]));
        chk("order_data",  res_data, t_exp[got]);
        chk("order_error", 32'(res_error), 32'd0);
        got++;
      end
    end
    chk("order_count", 32'(got), 32'd5);
    req_valid = 1'b0;
    tick();

    // Timeout with no response
    cfu_auto  = 1'b0;
    rsp_valid = 1'b0;
    push_one(10'h020, 32'd1, 32'd0);
    wait_issue("to_issue");
    repeat (255) tick();
    chk("to_not_early", 32'(res_valid), 32'd0);
    tick();
    chk("to_res_valid", 32'(res_valid), 32'd1);
    chk("to_res_error", 32'(res_error), 32'd1);
    chk("to_res_data",  res_data, 32'd0);
    chk("to_res_fid",   32'(res_function_id), 32'h020);
    tick();

    // Response on the timeout cycle wins
    push_one(10'h022, 32'd2, 32'd0);
    wait_issue("race_issue");
    repeat (255) tick();
    rsp_valid = 1'b1;
    rsp_payload_outputs_0 = 32'h12345678;
    tick();
    rsp_valid = 1'b0;
    chk("race_res_valid", 32'(res_valid), 32'd1);
    chk("race_res_error", 32'(res_error), 32'd0);
    chk("race_res_data",  res_data, 32'h12345678);
    tick();

    // Reset while waiting with three requests queued
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_function_id = 10'(10'h030 + i); req_in0 = 32'(i); req_in1 = '0;
      tick();
    end
    req_valid = 1'b0;
    chk("pre_rst_busy",      32'(busy), 32'd1);
    chk("pre_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_busy",      32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("mid_rst_stray",     32'(stray_count), 32'd0);
    reset    = 1'b0;
    cfu_auto = 1'b1;
    stale    = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (res_valid || cmd_valid) stale = 1'b1;
    end
    chk("post_rst_no_stale", 32'(stale), 32'd0);
    chk("post_rst_busy",     32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
